// File: rtl/target_filter.sv
// Per-frame target conditioner between the colour tracker and motor control.
// Validates detections, gates outliers, EMA-smooths x/y/radius and tracks acquisition/loss.
module target_filter #(
   parameter int unsigned ALPHA_SHIFT = 2,
   parameter int unsigned GATE        = 40,
   parameter int unsigned ACQ_FRAMES  = 3,
   parameter int unsigned LOST_FRAMES = 8,
   parameter int unsigned RAD_MIN     = 10,
   parameter int unsigned CENTER_X    = 160,
   parameter int unsigned CENTER_Y    = 120
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       frame_done_in,
   input  logic [8:0] x_in,
   input  logic [8:0] y_in,
   input  logic [6:0] rad_in,
   output logic [8:0] x_out,
   output logic [8:0] y_out,
   output logic [6:0] rad_out,
   output logic       valid_out,
   output logic       lost_out,
   output logic [1:0] state_out
);

   localparam int unsigned XW  = 9;
   localparam int unsigned RW  = 7;
   localparam int unsigned CW  = 4;
   localparam int unsigned XAW = XW + ALPHA_SHIFT;
   localparam int unsigned RAW = RW + ALPHA_SHIFT;

   typedef enum logic [1:0] {
      ST_LOST    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_TRACK   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [XAW-1:0] x_acc_q, x_acc_d, y_acc_q, y_acc_d;
   logic [RAW-1:0] r_acc_q, r_acc_d;
   logic [CW-1:0]  acq_q, acq_d, miss_q, miss_d;
   logic [XW-1:0]  x_q, x_d, y_q, y_d;
   logic [RW-1:0]  r_q, r_d;
   logic           valid_q, valid_d;
   logic           lost_q, lost_d;

   logic           det, hit;
   logic [CW-1:0]  acq_inc, miss_inc;
   logic [XAW-1:0] x_acc_upd, y_acc_upd, x_acc_rld, y_acc_rld;
   logic [RAW-1:0] r_acc_upd, r_acc_rld;
   logic signed [9:0] dx, dy;
   logic [9:0]     ax, ay;

   // Detection, distance gate against the current filtered position, and EMA candidates
   always_comb begin
      det       = (x_in != 9'h1FF) && (rad_in >= RW'(RAD_MIN));
      dx        = $signed({1'b0, x_in}) - $signed({1'b0, x_q});
      dy        = $signed({1'b0, y_in}) - $signed({1'b0, y_q});
      ax        = dx[9] ? 10'(-dx) : 10'(dx);
      ay        = dy[9] ? 10'(-dy) : 10'(dy);
      hit       = det && (ax <= 10'(GATE)) && (ay <= 10'(GATE));
      acq_inc   = (acq_q  == 4'd15) ? 4'd15 : acq_q  + 4'd1;
      miss_inc  = (miss_q == 4'd15) ? 4'd15 : miss_q + 4'd1;
      x_acc_rld = XAW'(x_in)   << ALPHA_SHIFT;
      y_acc_rld = XAW'(y_in)   << ALPHA_SHIFT;
      r_acc_rld = RAW'(rad_in) << ALPHA_SHIFT;
      x_acc_upd = x_acc_q - (x_acc_q >> ALPHA_SHIFT) + XAW'(x_in);
      y_acc_upd = y_acc_q - (y_acc_q >> ALPHA_SHIFT) + XAW'(y_in);
      r_acc_upd = r_acc_q - (r_acc_q >> ALPHA_SHIFT) + RAW'(rad_in);
   end

   // Next-state and next-output logic; nothing moves except on a frame pulse
   always_comb begin
      state_d = state_q;
      x_acc_d = x_acc_q;
      y_acc_d = y_acc_q;
      r_acc_d = r_acc_q;
      acq_d   = acq_q;
      miss_d  = miss_q;
      x_d     = x_q;
      y_d     = y_q;
      r_d     = r_q;
      valid_d = 1'b0;

      if (frame_done_in) begin
         valid_d = 1'b1;
         unique case (state_q)
            ST_LOST: begin
               if (det) begin
                  x_acc_d = x_acc_rld;
                  y_acc_d = y_acc_rld;
                  r_acc_d = r_acc_rld;
                  x_d     = x_in;
                  y_d     = y_in;
                  r_d     = rad_in;
                  acq_d   = 4'd1;
                  miss_d  = '0;
                  state_d = (ACQ_FRAMES == 1) ? ST_TRACK : ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (det) begin
                  x_acc_d = x_acc_upd;
                  y_acc_d = y_acc_upd;
                  r_acc_d = r_acc_upd;
                  x_d     = XW'(x_acc_upd >> ALPHA_SHIFT);
                  y_d     = XW'(y_acc_upd >> ALPHA_SHIFT);
                  r_d     = RW'(r_acc_upd >> ALPHA_SHIFT);
                  acq_d   = acq_inc;
                  if (acq_inc == CW'(ACQ_FRAMES)) begin
                     state_d = ST_TRACK;
                     miss_d  = '0;
                  end
               end else begin
                  state_d = ST_LOST;
                  x_d     = XW'(CENTER_X);
                  y_d     = XW'(CENTER_Y);
                  r_d     = '0;
                  acq_d   = '0;
               end
            end
            ST_TRACK: begin
               if (hit) begin
                  x_acc_d = x_acc_upd;
                  y_acc_d = y_acc_upd;
                  r_acc_d = r_acc_upd;
                  x_d     = XW'(x_acc_upd >> ALPHA_SHIFT);
                  y_d     = XW'(y_acc_upd >> ALPHA_SHIFT);
                  r_d     = RW'(r_acc_upd >> ALPHA_SHIFT);
                  miss_d  = '0;
               end else if (miss_inc == CW'(LOST_FRAMES)) begin
                  state_d = ST_LOST;
                  x_d     = XW'(CENTER_X);
                  y_d     = XW'(CENTER_Y);
                  r_d     = '0;
                  miss_d  = '0;
                  acq_d   = '0;
               end else begin
                  miss_d  = miss_inc;
               end
            end
            default: begin
               state_d = ST_LOST;
               x_d     = XW'(CENTER_X);
               y_d     = XW'(CENTER_Y);
               r_d     = '0;
               acq_d   = '0;
               miss_d  = '0;
            end
         endcase
      end

      lost_d = (state_d != ST_TRACK);
   end

   // State register; reset overrides a coincident frame pulse
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_LOST;
         x_acc_q <= '0;
         y_acc_q <= '0;
         r_acc_q <= '0;
         acq_q   <= '0;
         miss_q  <= '0;
         x_q     <= XW'(CENTER_X);
         y_q     <= XW'(CENTER_Y);
         r_q     <= '0;
         valid_q <= 1'b0;
         lost_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         x_acc_q <= x_acc_d;
         y_acc_q <= y_acc_d;
         r_acc_q <= r_acc_d;
         acq_q   <= acq_d;
         miss_q  <= miss_d;
         x_q     <= x_d;
         y_q     <= y_d;
         r_q     <= r_d;
         valid_q <= valid_d;
         lost_q  <= lost_d;
      end
   end

   assign x_out     = x_q;
   assign y_out     = y_q;
   assign rad_out   = r_q;
   assign valid_out = valid_q;
   assign lost_out  = lost_q;
   assign state_out = state_q;

endmodule
